// File: rtl/mux_eight_rr_arb_pkg.sv
// Shared definitions for the mux_eight round-robin arbiter.
//   NUM_REQ : number of requesters sharing the mux_eight datapath
//   SEL_W   : width of the mux select
//   state_t : arbiter FSM state encoding
package mux_eight_rr_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/mux_eight_rr_arb_if.sv
// Handshake bundle between the requesters and the arbiter.
//   req       : request vector, bit i = requester i wants the mux
//   rel       : release pulse from the current grant holder
//   s         : mux select driven to mux_eight.s
//   gnt       : one-hot grant (zero when no grant is active)
//   gnt_valid : a grant is active and s is stable
//   preempt   : one-cycle pulse when a grant was ended by timeout
// master = requester side, slave = arbiter side.
interface mux_eight_rr_arb_if;
  import mux_eight_rr_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               rel;
  logic [SEL_W-1:0]   s;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_valid;
  logic               preempt;

  modport master (output req, rel, input s, gnt, gnt_valid, preempt);
  modport slave  (input req, rel, output s, gnt, gnt_valid, preempt);

endinterface

// File: rtl/mux_eight_rr_arb_rr_pick8.sv
// Combinational round-robin picker: finds the first set request bit in the
// order ptr, ptr+1, ... wrapping 7 -> 0.
//   req : request vector
//   ptr : first position to consider
//   idx : index of the chosen requester (don't care when any = 0)
//   any : at least one request is set
module rr_pick8
  import mux_eight_rr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic [SEL_W-1:0]   idx,
  output logic               any
);

  logic [NUM_REQ-1:0] rot;
  logic [SEL_W-1:0]   off;

  // Rotate so that position ptr lands on bit 0; the 3-bit index sum wraps
  // naturally, which is exactly the search-order wrap.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    assign rot[gi] = req[SEL_W'(gi) + ptr];
  end

  // Lowest set bit of the rotated vector wins.
  always_comb begin
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = SEL_W'(i);
      end
    end
  end

  // Rotate back to an absolute requester index.
  assign idx = off + ptr;
  assign any = |req;

endmodule

// File: rtl/mux_eight_rr_arb.sv
// Round-robin arbiter sharing one 8:1 mux_eight among 8 requesters.
// A grant is held until the holder releases, drops its request, or reaches
// MAX_HOLD cycles (0 = no limit). One idle cycle separates consecutive grants
// so s never changes while gnt_valid is high.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of mux_eight_rr_arb_if (req, rel in; s, gnt,
//         gnt_valid, preempt out)
// CNT_W must satisfy 2**CNT_W > MAX_HOLD.
module mux_eight_rr_arb
  import mux_eight_rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  mux_eight_rr_arb_if.slave  bus
);

  localparam bit              HOLD_EN   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = HOLD_EN ? CNT_W'(MAX_HOLD - 1) : '0;

  state_t             state_reg, state_next;
  logic [SEL_W-1:0]   s_reg, s_next;
  logic [NUM_REQ-1:0] gnt_reg, gnt_next;
  logic               gnt_valid_reg, gnt_valid_next;
  logic               preempt_reg, preempt_next;
  logic [SEL_W-1:0]   ptr_reg, ptr_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  logic [SEL_W-1:0]   pick_idx;
  logic               pick_any;
  logic               rel_end, drop_end, time_end;

  rr_pick8 u_pick (
    .req (bus.req),
    .ptr (ptr_reg),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign rel_end  = bus.rel;
  assign drop_end = !bus.req[s_reg];
  // cnt counts completed grant cycles minus one, so matching MAX_HOLD-1
  // ends the grant after exactly MAX_HOLD valid cycles.
  assign time_end = HOLD_EN && (cnt_reg == HOLD_LAST);

  always_comb begin
    state_next     = state_reg;
    s_next         = s_reg;
    gnt_next       = gnt_reg;
    gnt_valid_next = gnt_valid_reg;
    preempt_next   = 1'b0;
    ptr_next       = ptr_reg;
    cnt_next       = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          state_next           = GRANT;
          s_next               = pick_idx;
          gnt_next             = '0;
          gnt_next[pick_idx]   = 1'b1;
          gnt_valid_next       = 1'b1;
          cnt_next             = '0;
        end
      end
      GRANT: begin
        cnt_next = cnt_reg + CNT_W'(1);
        if (rel_end || drop_end || time_end) begin
          state_next     = IDLE;
          gnt_next       = '0;
          gnt_valid_next = 1'b0;
          ptr_next       = s_reg + SEL_W'(1);
          // Release or drop wins over a coincident timeout.
          preempt_next   = time_end && !rel_end && !drop_end;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      s_reg         <= '0;
      gnt_reg       <= '0;
      gnt_valid_reg <= 1'b0;
      preempt_reg   <= 1'b0;
      ptr_reg       <= '0;
      cnt_reg       <= '0;
    end else begin
      state_reg     <= state_next;
      s_reg         <= s_next;
      gnt_reg       <= gnt_next;
      gnt_valid_reg <= gnt_valid_next;
      preempt_reg   <= preempt_next;
      ptr_reg       <= ptr_next;
      cnt_reg       <= cnt_next;
    end
  end

  assign bus.s         = s_reg;
  assign bus.gnt       = gnt_reg;
  assign bus.gnt_valid = gnt_valid_reg;
  assign bus.preempt   = preempt_reg;

endmodule

// File: tb/tb_mux_eight_rr_arb.sv
// Testbench for mux_eight_rr_arb: directed vector table, hand-written
// fairness and async-reset sequences, then randomized traffic against a
// behavioural model.
module tb_mux_eight_rr_arb;
  import mux_eight_rr_arb_pkg::*;

  localparam int MAXH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_eight_rr_arb_if bus_if ();

  mux_eight_rr_arb #(.MAX_HOLD(MAXH), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.req = '0;
    bus_if.rel = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    step();
  endtask

  // ---------------- behavioural model ----------------
  int          m_busy, m_holder, m_age, m_ptr, m_pre;
  logic [2:0]  m_s;

  task automatic model_reset();
    m_busy = 0; m_holder = 0; m_age = 0; m_ptr = 0; m_pre = 0; m_s = 3'd0;
  endtask

  // m_age = number of cycles the current grant has been visible.
  task automatic model_step(input logic [7:0] r, input logic rl);
    m_pre = 0;
    if (m_busy != 0) begin
      bit dropped = !r[m_holder];
      bit timed   = (MAXH != 0) && (m_age == MAXH);
      if (rl || dropped || timed) begin
        m_busy = 0;
        m_pre  = (timed && !rl && !dropped) ? 1 : 0;
        m_ptr  = (m_holder + 1) % 8;
      end else begin
        m_age++;
      end
    end else if (r != 8'h00) begin
      for (int k = 0; k < 8; k++) begin
        int i = (m_ptr + k) % 8;
        if (r[i]) begin
          m_busy = 1; m_holder = i; m_s = 3'(i); m_age = 1;
          break;
        end
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] req;
    logic       rel;
    logic [2:0] s;
    logic [7:0] gnt;
    logic       v;
    logic       p;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];

  initial begin
    tbl[0]  = '{8'h08, 1'b0, 3'd3, 8'h08, 1'b1, 1'b0}; // single requester
    tbl[1]  = '{8'h08, 1'b1, 3'd3, 8'h00, 1'b0, 1'b0}; // release -> ptr=4
    tbl[2]  = '{8'h41, 1'b0, 3'd6, 8'h40, 1'b1, 1'b0}; // ptr=4 skips bit 0
    tbl[3]  = '{8'h41, 1'b1, 3'd6, 8'h00, 1'b0, 1'b0}; // ptr=7
    tbl[4]  = '{8'h41, 1'b0, 3'd0, 8'h01, 1'b1, 1'b0}; // wrap to 0
    tbl[5]  = '{8'h41, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0}; // ptr=1
    tbl[6]  = '{8'h04, 1'b0, 3'd2, 8'h04, 1'b1, 1'b0};
    tbl[7]  = '{8'h04, 1'b0, 3'd2, 8'h04, 1'b1, 1'b0};
    tbl[8]  = '{8'h00, 1'b0, 3'd2, 8'h00, 1'b0, 1'b0}; // drop, no preempt
    tbl[9]  = '{8'h0C, 1'b0, 3'd3, 8'h08, 1'b1, 1'b0}; // ptr=3 after drop
    tbl[10] = '{8'h0C, 1'b1, 3'd3, 8'h00, 1'b0, 1'b0}; // ptr=4
    tbl[11] = '{8'h20, 1'b0, 3'd5, 8'h20, 1'b1, 1'b0}; // timeout cycle 1
    tbl[12] = '{8'h20, 1'b0, 3'd5, 8'h20, 1'b1, 1'b0};
    tbl[13] = '{8'h20, 1'b0, 3'd5, 8'h20, 1'b1, 1'b0};
    tbl[14] = '{8'h20, 1'b0, 3'd5, 8'h20, 1'b1, 1'b0}; // cycle 4
    tbl[15] = '{8'h20, 1'b0, 3'd5, 8'h00, 1'b0, 1'b1}; // gap with preempt
    tbl[16] = '{8'h20, 1'b0, 3'd5, 8'h20, 1'b1, 1'b0}; // re-grant
    tbl[17] = '{8'h20, 1'b0, 3'd5, 8'h20, 1'b1, 1'b0};
    tbl[18] = '{8'h20, 1'b0, 3'd5, 8'h20, 1'b1, 1'b0};
    tbl[19] = '{8'h20, 1'b0, 3'd5, 8'h20, 1'b1, 1'b0}; // cycle 4
    tbl[20] = '{8'h20, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0}; // rel + timeout: no preempt
    tbl[21] = '{8'h00, 1'b0, 3'd5, 8'h00, 1'b0, 1'b0}; // idle holds s
    tbl[22] = '{8'h00, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0}; // rel ignored when idle
  end

  initial begin
    int w;
    int ngrant;
    #1;

    // ---------- reset state ----------
    do_reset();
    check("reset_s", 32'(bus_if.s), 32'd0);
    check("reset_gnt", 32'(bus_if.gnt), 32'd0);
    check("reset_valid", 32'(bus_if.gnt_valid), 32'd0);
    check("reset_preempt", 32'(bus_if.preempt), 32'd0);

    // ---------- table ----------
    for (int r = 0; r < NV; r++) begin
      bus_if.req = tbl[r].req;
      bus_if.rel = tbl[r].rel;
      step();
      $display("vec %0d req=%02h rel=%0b -> s=%0d gnt=%02h v=%0b p=%0b", r,
               tbl[r].req, tbl[r].rel, bus_if.s, bus_if.gnt, bus_if.gnt_valid, bus_if.preempt);
      check($sformatf("vec%0d_s", r), 32'(bus_if.s), 32'(tbl[r].s));
      check($sformatf("vec%0d_gnt", r), 32'(bus_if.gnt), 32'(tbl[r].gnt));
      check($sformatf("vec%0d_valid", r), 32'(bus_if.gnt_valid), 32'(tbl[r].v));
      check($sformatf("vec%0d_preempt", r), 32'(bus_if.preempt), 32'(tbl[r].p));
    end
    bus_if.rel = 1'b0;

    // ---------- fairness: all requesting, rel on 2nd grant cycle ----------
    do_reset();
    bus_if.req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      w = 0;
      do begin
        step();
        w++;
      end while (!bus_if.gnt_valid && w < 4);
      check($sformatf("fair%0d_latency", k), 32'(w), 32'd1);
      check($sformatf("fair%0d_s", k), 32'(bus_if.s), 32'(k % 8));
      check($sformatf("fair%0d_gnt", k), 32'(bus_if.gnt), 32'(8'h01 << (k % 8)));
      $display("fair grant %0d s=%0d gnt=%02h", k, bus_if.s, bus_if.gnt);
      step();
      check($sformatf("fair%0d_hold", k), 32'(bus_if.gnt_valid), 32'd1);
      bus_if.rel = 1'b1;
      step();
      bus_if.rel = 1'b0;
      check($sformatf("fair%0d_gap", k), 32'(bus_if.gnt_valid), 32'd0);
    end

    // ---------- async reset during a grant ----------
    do_reset();
    bus_if.req = 8'h04;
    step();
    check("ar_pre_valid", 32'(bus_if.gnt_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    $display("async reset mid-cycle: s=%0d gnt=%02h v=%0b p=%0b",
             bus_if.s, bus_if.gnt, bus_if.gnt_valid, bus_if.preempt);
    check("ar_s", 32'(bus_if.s), 32'd0);
    check("ar_gnt", 32'(bus_if.gnt), 32'd0);
    check("ar_valid", 32'(bus_if.gnt_valid), 32'd0);
    check("ar_preempt", 32'(bus_if.preempt), 32'd0);
    #2 rst = 1'b0;
    bus_if.req = 8'h80;
    step();
    check("ar_after_s", 32'(bus_if.s), 32'd7);
    check("ar_after_gnt", 32'(bus_if.gnt), 32'h80);
    check("ar_after_valid", 32'(bus_if.gnt_valid), 32'd1);
    check("ar_after_preempt", 32'(bus_if.preempt), 32'd0);

    // ---------- randomized traffic vs model ----------
    do_reset();
    model_reset();
    ngrant = 0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) bus_if.req = 8'($urandom_range(0, 255));
      bus_if.rel = ($urandom_range(0, 7) == 0);
      step();
      begin
        int was_busy = m_busy;
        model_step(bus_if.req, bus_if.rel);
        if (was_busy == 0 && m_busy != 0) begin
          ngrant++;
          $display("rand cyc %0d grant %0d to s=%0d", c, ngrant, m_s);
        end
      end
      check($sformatf("rand%0d_s", c), 32'(bus_if.s), 32'(m_s));
      check($sformatf("rand%0d_gnt", c), 32'(bus_if.gnt),
            (m_busy != 0) ? 32'(8'h01 << m_holder) : 32'd0);
      check($sformatf("rand%0d_valid", c), 32'(bus_if.gnt_valid), 32'(m_busy != 0));
      check($sformatf("rand%0d_preempt", c), 32'(bus_if.preempt), 32'(m_pre));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
